// File: rtl/handshake_responder_v_pkg.sv
// Shared definitions for four-phase handshake blocks: FSM state encoding.
`timescale 1ns/1ps
package handshake_responder_v_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } hsState_e;

endpackage

// File: rtl/handshake_responder_v_sync.sv
// Multi-flop single-bit synchronizer with asynchronous active-high clear.
`timescale 1ns/1ps
module async_bit_synchronizer_v #(
  parameter int STAGES = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic asyncBit_i,
  output logic syncBit_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], asyncBit_i};
    end
  end

  assign syncBit_o = chain_q[STAGES-1];

endmodule

// File: rtl/handshake_responder_v.sv
// Receiving end of a four-phase req/ack handshake from a foreign clock domain,
// presenting each captured word as a valid/ready stream with end-to-end flow control.
`timescale 1ns/1ps
module handshake_responder_v
  import handshake_responder_v_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int STAGES      = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Req_in,
  input  logic [WORD_LENGTH-1:0] Data_in,
  output logic                   Ack_out,
  output logic [WORD_LENGTH-1:0] Rx_data,
  output logic                   Rx_valid,
  input  logic                   Rx_ready,
  output logic                   Busy,
  output logic                   Proto_err,
  output logic [CNT_WIDTH-1:0]   Word_count
);

  if (WORD_LENGTH < 1) begin : gBadWidth
    $error("handshake_responder_v: WORD_LENGTH must be > 0");
  end
  if (STAGES < 2) begin : gBadStages
    $error("handshake_responder_v: STAGES must be >= 2");
  end

  logic reqSync;

  async_bit_synchronizer_v #(
    .STAGES(STAGES)
  ) uReqSync (
    .Clock     (Clock),
    .Reset     (Reset),
    .asyncBit_i(Req_in),
    .syncBit_o (reqSync)
  );

  hsState_e                state_q;
  (* ASYNC_REG = "TRUE" *) logic [WORD_LENGTH-1:0] rxData_q;
  logic                    rxValid_q;
  logic                    ack_q;
  logic                    protoErr_q;
  logic                    errSeen_q;
  logic [CNT_WIDTH-1:0]    count_q;

  // Data_in is captured without synchronization: the initiator holds it stable
  // for as long as Req_in is high, and we only sample after req has crossed.
  // errSeen_q remembers an early req drop so the accept path skips ACK.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      ack_q      <= 1'b0;
      protoErr_q <= 1'b0;
      errSeen_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      protoErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (reqSync) begin
            rxData_q  <= Data_in;
            rxValid_q <= 1'b1;
            errSeen_q <= 1'b0;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (!reqSync && !errSeen_q) begin
            protoErr_q <= 1'b1;
            errSeen_q  <= 1'b1;
          end
          if (rxValid_q && Rx_ready) begin
            rxValid_q <= 1'b0;
            count_q   <= count_q + CNT_WIDTH'(1);
            if (!reqSync || errSeen_q) begin
              state_q <= IDLE;
            end else begin
              ack_q   <= 1'b1;
              state_q <= ACK;
            end
          end
        end
        ACK: begin
          if (!reqSync) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q     <= 1'b0;
          rxValid_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign Ack_out    = ack_q;
  assign Rx_data    = rxData_q;
  assign Rx_valid   = rxValid_q;
  assign Busy       = (state_q != IDLE);
  assign Proto_err  = protoErr_q;
  assign Word_count = count_q;

endmodule

// File: tb/tb_handshake_responder_v.sv
// Self-checking bench: directed latency/backpressure/error/reset scenarios plus a
// randomized initiator/consumer run scored against an in-order word queue.
`timescale 1ns/1ps
module tb_handshake_responder_v;

  localparam int WL = 8;
  localparam int CW = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Req_in;
  logic [WL-1:0] Data_in;
  logic          Ack_out;
  logic [WL-1:0] Rx_data;
  logic          Rx_valid;
  logic          Rx_ready;
  logic          Busy;
  logic          Proto_err;
  logic [CW-1:0] Word_count;

  int total = 0;
  int bad   = 0;
  int expCount = 0;
  logic monitorOn = 1'b0;
  logic initDone  = 1'b0;
  logic [WL-1:0] expQ[$];

  handshake_responder_v #(
    .WORD_LENGTH(WL),
    .STAGES     (2),
    .CNT_WIDTH  (CW)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Req_in    (Req_in),
    .Data_in   (Data_in),
    .Ack_out   (Ack_out),
    .Rx_data   (Rx_data),
    .Rx_valid  (Rx_valid),
    .Rx_ready  (Rx_ready),
    .Busy      (Busy),
    .Proto_err (Proto_err),
    .Word_count(Word_count)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [WL-1:0] data);
    Data_in = data;
    Req_in  = req;
  endtask

  task automatic stepEdge(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic waitAck(input logic value, input string tag);
    int n = 0;
    while (Ack_out !== value && n < 20000) begin
      #1;
      n++;
    end
    if (n >= 20000) checkOutput(tag, 32'(Ack_out), 32'(value));
  endtask

  // Consumer-side scoreboard: every accepted word must match the oldest request.
  always @(negedge Clock) begin
    if (monitorOn) begin
      if (Proto_err) checkOutput("randNoProtoErr", 32'(Proto_err), 32'd0);
      if (Rx_valid && Rx_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("randUnexpected", 32'd1, 32'd0);
        end else begin
          checkOutput("randOrder", 32'(Rx_data), 32'(expQ.pop_front()));
        end
        expCount = (expCount + 1) % (1 << CW);
      end
    end
  end

  initial begin
    int pulses;
    int ackSeen;
    Reset = 1'b1;
    Rx_ready = 1'b0;
    applyStimulus(1'b0, '0);
    #12;
    checkOutput("inResetAck", 32'(Ack_out), 32'd0);
    checkOutput("inResetValid", 32'(Rx_valid), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      stepEdge(1);
      checkOutput("idleAck", 32'(Ack_out), 32'd0);
      checkOutput("idleValid", 32'(Rx_valid), 32'd0);
      checkOutput("idleBusy", 32'(Busy), 32'd0);
      checkOutput("idleErr", 32'(Proto_err), 32'd0);
      checkOutput("idleData", 32'(Rx_data), 32'd0);
      checkOutput("idleCount", 32'(Word_count), 32'd0);
    end

    // Basic transfer with consumer always ready
    @(negedge Clock);
    Rx_ready = 1'b1;
    applyStimulus(1'b1, 8'hA5);
    stepEdge(2);
    checkOutput("latEarlyValid", 32'(Rx_valid), 32'd0);
    stepEdge(1);
    checkOutput("latValid", 32'(Rx_valid), 32'd1);
    checkOutput("latData", 32'(Rx_data), 32'hA5);
    checkOutput("latBusy", 32'(Busy), 32'd1);
    stepEdge(1);
    expCount = 1;
    checkOutput("acceptAck", 32'(Ack_out), 32'd1);
    checkOutput("acceptValid", 32'(Rx_valid), 32'd0);
    checkOutput("acceptCount", 32'(Word_count), 32'(expCount));
    @(negedge Clock);
    applyStimulus(1'b0, 8'hA5);
    stepEdge(2);
    checkOutput("dropAckHeld", 32'(Ack_out), 32'd1);
    stepEdge(1);
    checkOutput("dropAckLow", 32'(Ack_out), 32'd0);
    checkOutput("dropBusy", 32'(Busy), 32'd0);

    // Backpressure: consumer stalls for 50 cycles
    @(negedge Clock);
    Rx_ready = 1'b0;
    applyStimulus(1'b1, 8'h5A);
    stepEdge(3);
    checkOutput("bpValid", 32'(Rx_valid), 32'd1);
    for (int i = 0; i < 50; i++) begin
      stepEdge(1);
      checkOutput("bpAck", 32'(Ack_out), 32'd0);
      checkOutput("bpData", 32'(Rx_data), 32'h5A);
      checkOutput("bpValidHeld", 32'(Rx_valid), 32'd1);
      checkOutput("bpBusy", 32'(Busy), 32'd1);
    end
    @(negedge Clock);
    Rx_ready = 1'b1;
    stepEdge(1);
    expCount = 2;
    checkOutput("bpAcceptAck", 32'(Ack_out), 32'd1);
    checkOutput("bpAcceptValid", 32'(Rx_valid), 32'd0);
    checkOutput("bpAcceptCount", 32'(Word_count), 32'(expCount));
    @(negedge Clock);
    Rx_ready = 1'b0;
    applyStimulus(1'b0, 8'h5A);
    stepEdge(3);
    checkOutput("bpDropAck", 32'(Ack_out), 32'd0);
    checkOutput("bpSingleAccept", 32'(Word_count), 32'(expCount));

    // Initiator drops Req while the word is still held
    @(negedge Clock);
    applyStimulus(1'b1, 8'hC3);
    stepEdge(3);
    checkOutput("errValid", 32'(Rx_valid), 32'd1);
    @(negedge Clock);
    applyStimulus(1'b0, 8'hC3);
    pulses = 0;
    ackSeen = 0;
    for (int i = 0; i < 10; i++) begin
      stepEdge(1);
      if (Proto_err) pulses++;
      if (Ack_out) ackSeen++;
    end
    checkOutput("errPulseCount", 32'(pulses), 32'd1);
    checkOutput("errNoAck", 32'(ackSeen), 32'd0);
    checkOutput("errWordKept", 32'(Rx_valid), 32'd1);
    checkOutput("errDataKept", 32'(Rx_data), 32'hC3);
    @(negedge Clock);
    Rx_ready = 1'b1;
    stepEdge(1);
    expCount = 3;
    checkOutput("errAcceptValid", 32'(Rx_valid), 32'd0);
    checkOutput("errAcceptCount", 32'(Word_count), 32'(expCount));
    checkOutput("errIdle", 32'(Busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      stepEdge(1);
      checkOutput("errAckLow", 32'(Ack_out), 32'd0);
    end

    // Reset while in ACK with Req still high
    @(negedge Clock);
    applyStimulus(1'b1, 8'h3C);
    stepEdge(4);
    checkOutput("rstPreAck", 32'(Ack_out), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    expCount = 0;
    checkOutput("rstAsyncAck", 32'(Ack_out), 32'd0);
    checkOutput("rstAsyncValid", 32'(Rx_valid), 32'd0);
    checkOutput("rstAsyncBusy", 32'(Busy), 32'd0);
    checkOutput("rstAsyncCount", 32'(Word_count), 32'(expCount));
    @(negedge Clock);
    Rx_ready = 1'b0;
    Reset = 1'b0;
    stepEdge(3);
    checkOutput("rstRecapValid", 32'(Rx_valid), 32'd1);
    checkOutput("rstRecapData", 32'(Rx_data), 32'h3C);
    @(negedge Clock);
    Rx_ready = 1'b1;
    stepEdge(1);
    expCount = 1;
    checkOutput("rstRecapCount", 32'(Word_count), 32'(expCount));
    @(negedge Clock);
    applyStimulus(1'b0, 8'h3C);
    stepEdge(3);
    checkOutput("rstRecapAckLow", 32'(Ack_out), 32'd0);

    // Randomized back-to-back transfers; counter wraps at 16
    @(negedge Clock);
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    expCount = 0;
    monitorOn = 1'b1;
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          logic [WL-1:0] w;
          #($urandom_range(1, 23));
          w = WL'($urandom);
          Data_in = w;
          expQ.push_back(w);
          #1;
          Req_in = 1'b1;
          waitAck(1'b1, "randAckRiseTimeout");
          #($urandom_range(1, 31));
          Req_in = 1'b0;
          waitAck(1'b0, "randAckFallTimeout");
        end
        initDone = 1'b1;
      end
      begin
        while (!initDone) begin
          @(posedge Clock);
          #2;
          Rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    stepEdge(5);
    monitorOn = 1'b0;
    checkOutput("randQueueEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("randWrapCount", 32'(Word_count), 32'(expCount));
    checkOutput("randFinalIdle", 32'(Busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
